// File: rtl/conv_pkg.sv
// Shared defaults for the conv datapath: pixel width, frame geometry, and counter widths.
// conv_unit and the downstream stages also import this package.
package conv_pkg;

  localparam int DEF_WIDTH = 9;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_COL_W = $clog2(DEF_IMG_W);
  localparam int DEF_ROW_W = $clog2(DEF_IMG_H);

endpackage

// File: rtl/line_delay.sv
// Delays din by DEPTH enabled beats using a circular RAM with one read/write pointer.
// The pointer advances only on enabled beats, so idle cycles leave the delay frozen.
module line_delay #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  // Read before write at the same slot: the entry being overwritten is the one DEPTH beats old.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Builds 3x3 windows from a raster pixel stream; each window appears one cycle after its last pixel.
// There is no backpressure: every in_valid beat is consumed, and windows that would need padding are suppressed.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] w00,
  output logic [WIDTH-1:0] w01,
  output logic [WIDTH-1:0] w02,
  output logic [WIDTH-1:0] w10,
  output logic [WIDTH-1:0] w11,
  output logic [WIDTH-1:0] w12,
  output logic [WIDTH-1:0] w20,
  output logic [WIDTH-1:0] w21,
  output logic [WIDTH-1:0] w22,
  output logic             frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [WIDTH-1:0] ld0_out;
  logic [WIDTH-1:0] ld1_out;
  logic             shift_en;

  // A pixel that arrives in the same cycle as reset is dropped, so the line delays must not see it.
  assign shift_en = in_valid && !rst_n;

  line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_ld0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .din   (in_data),
    .dout  (ld0_out)
  );

  line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_ld1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .din   (ld0_out),
    .dout  (ld1_out)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      {w00, w01, w02, w10, w11, w12, w20, w21, w22} <= '0;
    end else if (in_valid) begin
      {w00, w01} <= {w01, w02};
      {w10, w11} <= {w11, w12};
      {w20, w21} <= {w21, w22};
      w02        <= ld1_out;
      w12        <= ld0_out;
      w22        <= in_data;
      // Counters still hold this pixel's position here; they advance below.
      out_valid  <= (row >= ROW_TWO) && (col >= COL_TWO);
      frame_done <= (row == ROW_LAST) && (col == COL_LAST);
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x4 frame; every window is checked against hand-derived pixel values.
module tb_conv_window_gen;

  localparam int WIDTH = 9;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             frame_done;
  logic [WIDTH-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;

  int errors = 0;
  int checks = 0;

  // Values captured one time step after each clock edge.
  logic        obs_vld;
  logic        obs_fd;
  logic [80:0] obs_win;

  conv_window_gen #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .w00        (w00),
    .w01        (w01),
    .w02        (w02),
    .w10        (w10),
    .w11        (w11),
    .w12        (w12),
    .w20        (w20),
    .w21        (w21),
    .w22        (w22),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected window centred on pixel value c (relative to base), with w00 in the top bits.
  function automatic logic [80:0] exp_win(int base, int c);
    logic [80:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        v[(8 - (r * 3 + k)) * 9 +: 9] = 9'(base + c + (r - 1) * IMG_W + (k - 1));
    return v;
  endfunction

  function automatic int win_sum(logic [80:0] v);
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(v[i * 9 +: 9]);
    return s;
  endfunction

  task automatic push(input logic rst, input logic v, input int d);
    rst_n    = rst;
    in_valid = v;
    in_data  = 9'(d);
    @(posedge clk);
    #1;
    obs_vld = out_valid;
    obs_fd  = frame_done;
    obs_win = {w00, w01, w02, w10, w11, w12, w20, w21, w22};
  endtask

  task automatic test_reset;
    push(1'b1, 1'b0, 0);
    push(1'b1, 1'b0, 0);
    checks++;
    if ({obs_vld, obs_fd} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: out_valid/frame_done=%b required 00", {obs_vld, obs_fd});
    end
    checks++;
    if (obs_win !== 81'd0) begin
      errors++;
      $display("FAIL reset_window: window=%h required 0", obs_win);
    end
    rst_n = 1'b0;
  endtask

  task automatic test_basic(input string tag, input int base);
    int nwin;
    nwin = 0;
    for (int p = 0; p < IMG_W * IMG_H; p++) begin
      int  r, c;
      logic ev, ef;
      r = p / IMG_W;
      c = p % IMG_W;
      ev = (r >= 2) && (c >= 2);
      ef = (p == IMG_W * IMG_H - 1);
      push(1'b0, 1'b1, base + p);
      checks++;
      if (obs_vld !== ev) begin
        errors++;
        $display("FAIL %s_valid p=%0d: out_valid=%b required %b", tag, p, obs_vld, ev);
      end
      checks++;
      if (obs_fd !== ef) begin
        errors++;
        $display("FAIL %s_frame_done p=%0d: frame_done=%b required %b", tag, p, obs_fd, ef);
      end
      if (obs_vld) begin
        nwin++;
        checks++;
        if (obs_win !== exp_win(base, p - IMG_W - 1)) begin
          errors++;
          $display("FAIL %s_window p=%0d: window=%h required %h", tag, p, obs_win, exp_win(base, p - IMG_W - 1));
        end
        if (base >= 100) begin
          checks++;
          for (int i = 0; i < 9; i++)
            if (int'(obs_win[i * 9 +: 9]) < 100) begin
              errors++;
              $display("FAIL %s_old_frame_leak p=%0d: element=%0d required >=100", tag, p, obs_win[i * 9 +: 9]);
              break;
            end
        end
        if (nwin == 1 && base == 0) begin
          checks++;
          if (win_sum(obs_win) !== 54) begin
            errors++;
            $display("FAIL %s_first_sum: sum=%0d required 54", tag, win_sum(obs_win));
          end
        end
      end
    end
    checks++;
    if (nwin !== 6) begin
      errors++;
      $display("FAIL %s_window_count: got %0d required 6", tag, nwin);
    end
  endtask

  task automatic test_gapped;
    int nwin;
    nwin = 0;
    for (int p = 0; p < IMG_W * IMG_H; p++) begin
      int  r, c;
      logic ev;
      r = p / IMG_W;
      c = p % IMG_W;
      ev = (r >= 2) && (c >= 2);
      push(1'b0, 1'b1, p);
      checks++;
      if (obs_vld !== ev || (obs_vld && obs_win !== exp_win(0, p - IMG_W - 1))) begin
        errors++;
        $display("FAIL gapped_window p=%0d: valid=%b window=%h required valid=%b window=%h",
                 p, obs_vld, obs_win, ev, exp_win(0, p - IMG_W - 1));
      end
      if (obs_vld) nwin++;
      push(1'b0, 1'b0, 9'h1ff);
      checks++;
      if ({obs_vld, obs_fd} !== 2'b00) begin
        errors++;
        $display("FAIL gapped_idle p=%0d: out_valid/frame_done=%b required 00", p, {obs_vld, obs_fd});
      end
    end
    checks++;
    if (nwin !== 6) begin
      errors++;
      $display("FAIL gapped_window_count: got %0d required 6", nwin);
    end
  endtask

  task automatic test_back_to_back;
    test_basic("b2b_a", 0);
    test_basic("b2b_b", 100);
  endtask

  task automatic test_mid_reset;
    for (int p = 0; p <= 7; p++) push(1'b0, 1'b1, p);
    push(1'b1, 1'b1, 99);
    checks++;
    if ({obs_vld, obs_fd} !== 2'b00 || obs_win !== 81'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%b fd=%b window=%h required all 0", obs_vld, obs_fd, obs_win);
    end
    test_basic("after_reset", 0);
  endtask

  initial begin
    test_reset;
    test_basic("basic", 0);
    test_gapped;
    test_back_to_back;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
